// File: rtl/pool_pkg.sv
// pool_pkg: feeder state encoding and width helpers shared by the pooling blocks
package pool_pkg;
  typedef enum logic [1:0] {FILL, DRAIN, FILL_DRAIN} state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int win_px(input int k);
    return k * k;
  endfunction
endpackage

// File: rtl/pool_window_feeder_strip_buffer.sv
// strip_buffer: one strip of pixels, one write port, one registered read port
module strip_buffer import pool_pkg::*; #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int AW = cw(N)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: buffers KERNAL_SIZE-row strips and replays them window by window
// POOL_FEEDER_PINGPONG_EN selects two strip buffers so filling overlaps draining.
module pool_window_feeder import pool_pkg::*; #(
  parameter int KERNAL_SIZE = 2,
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAP_WIDTH = 8,
  parameter int MAP_HEIGHT = 8
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0]   neuron_in,
  output logic                          out_valid,
  output logic [KERNAL_SIZE**2-1:0]     count,
  output logic [DEPTH*DATA_WIDTH-1:0]   neuron_out,
  output logic                          frame_done
);
  localparam int K = KERNAL_SIZE, KK = win_px(K), MW = MAP_WIDTH, N = K * MW, S = MAP_HEIGHT / K;
  localparam int DW = DEPTH * DATA_WIDTH, AW = cw(N), IW = cw(N + 1), CW = cw(MW), RW = cw(K), SW = cw(S);
`ifdef POOL_FEEDER_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam bit PP = NBUF == 2;
  localparam logic [CW-1:0] COL_MAX = CW'(MW - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(K - 1);
  localparam logic [SW-1:0] STRIP_MAX = SW'(S - 1);
  localparam logic [IW-1:0] N_I = IW'(N), LAST_I = IW'(N - 1);
  localparam logic [KK-1:0] KK_C = KK'(KK);
  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] strip;
  logic [IW-1:0] d, rd_idx;
  logic [AW-1:0] wr_addr, rd_addr;
  logic wb, rb, sel, sel_q, acc, strip_done, drain_end, start, issue, last_px;
  logic [DW-1:0] rdata [NBUF];
  assign acc = in_valid && in_ready;
  assign strip_done = acc && col == COL_MAX && row == ROW_MAX;
  assign drain_end = d == N_I;
  assign last_px = rd_idx == LAST_I;
  assign wr_addr = AW'(int'(row) * MW + int'(col));
  // window w, pixel p of the strip: row p/K, column w*K + p%K
  assign rd_addr = AW'((int'(rd_idx) % KK) / K * MW + int'(rd_idx) / KK * K + int'(rd_idx) % K);
  assign neuron_out = (NBUF > 1 && sel_q) ? rdata[NBUF-1] : rdata[0];
  for (genvar i = 0; i < NBUF; i++) begin : g_buf
    strip_buffer #(.W(DW), .N(N), .AW(AW)) u_buf (
      .clk(clk), .reset(reset),
      .we(acc && wb == 1'(i)), .wr_addr(wr_addr), .wr_data(neuron_in),
      .re(issue && sel == 1'(i)), .rd_addr(rd_addr), .rd_data(rdata[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FILL;
    else state <= state_nxt;
  // in DRAIN with two buffers a completed strip is always waiting behind the active one
  always_comb begin
    state_nxt = state == FILL  ? (start ? (PP ? FILL_DRAIN : DRAIN) : FILL)
              : state == DRAIN ? (drain_end ? (PP ? FILL_DRAIN : FILL) : DRAIN)
              : drain_end      ? (strip_done ? FILL_DRAIN : FILL)
              :                  (strip_done ? DRAIN : FILL_DRAIN);
  end
  always_comb begin
    in_ready = state != DRAIN;
    start = (PP && state == DRAIN && drain_end) ||
            (strip_done && (state == FILL || (state == FILL_DRAIN && drain_end)));
    issue = start || (state != FILL && !drain_end);
    rd_idx = start ? '0 : d;
    sel = !start ? rb : state == DRAIN ? !rb : wb;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col <= '0;
      row <= '0;
      strip <= '0;
      d <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      sel_q <= 1'b0;
      out_valid <= 1'b0;
      count <= '0;
      frame_done <= 1'b0;
    end else begin
      if (acc) col <= col == COL_MAX ? '0 : col + 1'b1;
      if (acc && col == COL_MAX) row <= row == ROW_MAX ? '0 : row + 1'b1;
      if (issue && last_px) strip <= strip == STRIP_MAX ? '0 : strip + 1'b1;
      wb <= wb ^ (PP && strip_done);
      if (start) rb <= sel;
      if (issue) sel_q <= sel;
      d <= issue ? rd_idx + 1'b1 : '0;
      out_valid <= issue;
      count <= issue ? (count == KK_C ? KK'(1) : count + 1'b1) : '0;
      frame_done <= issue && last_px && strip == STRIP_MAX;
    end
endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder: random and directed streams checked against a window-order model
module tb_pool_window_feeder;
  localparam int K = 2, MW = 4, MH = 4, DW = 16, NS = K * MW, FR = MW * MH;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, frame_done;
  logic [DW-1:0] neuron_in = '0, neuron_out;
  logic [K*K-1:0] count;
  int errs = 0, checks = 0;
  typedef struct {logic [DW-1:0] v; int c; bit fd;} exp_t;
  exp_t q[$];
  logic [DW-1:0] pix [FR];
  int n_acc = 0, low_run = 0, max_low = 0;
  bit first_due = 0;

  pool_window_feeder #(.KERNAL_SIZE(K), .DEPTH(1), .DATA_WIDTH(DW), .MAP_WIDTH(MW), .MAP_HEIGHT(MH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .neuron_in(neuron_in),
    .out_valid(out_valid), .count(count), .neuron_out(neuron_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // strip s of the frame: windows left to right, each window row-major
  task automatic push_strip(input int s);
    exp_t e;
    for (int w = 0; w < MW / K; w++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          e.v = pix[(s * K + r) * MW + w * K + c];
          e.c = r * K + c + 1;
          e.fd = s == MH / K - 1 && w == MW / K - 1 && r == K - 1 && c == K - 1;
          q.push_back(e);
        end
  endtask

  task automatic accept(input logic [DW-1:0] data);
    pix[n_acc] = data;
    n_acc++;
    if (n_acc % NS == 0) begin
      push_strip(n_acc / NS - 1);
      first_due = 1;
    end
    if (n_acc == FR) n_acc = 0;
  endtask

  task automatic observe();
    exp_t e;
    if (first_due) chk("first_latency", out_valid, 1);
    first_due = 0;
    if (out_valid) begin
      if (q.size() == 0) chk("extra_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("pixel", neuron_out, e.v);
        chk("count", count, e.c);
        chk("frame_done", frame_done, e.fd);
      end
    end else begin
      chk("idle_count", count, 0);
      chk("idle_frame_done", frame_done, 0);
    end
    if (!in_ready) low_run++;
    else if (low_run != 0) begin
`ifndef POOL_FEEDER_PINGPONG_EN
      chk("ready_low_len", low_run, NS);
`endif
      if (low_run > max_low) max_low = low_run;
      low_run = 0;
    end
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] data, output bit acc);
    @(negedge clk);
    observe();
    in_valid = v;
    neuron_in = data;
    acc = v && in_ready;
    if (acc) accept(data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid = 0;
    q.delete();
    n_acc = 0;
    first_due = 0;
    low_run = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_neuron_out", neuron_out, 0);
    reset = 0;
    #1 chk("rst_in_ready", in_ready, 1);
  endtask

  // mode 0 continuous valid, 1 toggling valid, 2 random valid; raster: data = frame index
  task automatic stream(input int npix, input int mode, input bit raster);
    int sent = 0, guard = 0;
    bit v, a;
    logic [DW-1:0] dat;
    dat = raster ? DW'(n_acc) : DW'($urandom);
    while (sent < npix && guard < 2000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? guard % 2 == 0 : $urandom_range(0, 3) != 0;
      cycle(v, dat, a);
      if (a) begin
        sent++;
        dat = raster ? DW'(n_acc) : DW'($urandom);
      end
      guard++;
    end
    if (guard >= 2000) chk("stream_timeout", sent, npix);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 60 && q.size() != 0; i++) cycle(0, '0, a);
    cycle(0, '0, a);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit a;
    do_reset();
    stream(FR, 0, 1);
    drain();
    stream(FR, 1, 1);
    drain();
    stream(6, 0, 1);
    do_reset();
    stream(FR, 0, 1);
    drain();
    stream(NS, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, a);
    do_reset();
    stream(3 * FR, 2, 0);
    drain();
    stream(2 * FR, 0, 0);
    drain();
`ifdef POOL_FEEDER_PINGPONG_EN
    chk("pingpong_never_stall", max_low, 0);
`else
    chk("single_stall_len", max_low, NS);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pool_window_feeder.md
POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 Parameter KERNAL_SIZE, default 2, pooling window edge and stride (non-overlapping windows).
REQ-002 Parameter DEPTH, default 8, channels per pixel.
REQ-003 Parameter DATA_WIDTH, default 16, bits per channel.
REQ-004 Parameter MAP_WIDTH, default 8, pixels per feature-map row; SHALL be a multiple of KERNAL_SIZE.
REQ-005 Parameter MAP_HEIGHT, default 8, rows per frame; SHALL be a multiple of KERNAL_SIZE.
REQ-006 clk  input  1  single clock, all state on posedge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 in_valid  input  1  upstream pixel valid.
REQ-009 in_ready  output  1  feeder accepts pixel when in_valid && in_ready.
REQ-010 neuron_in  input  DEPTH*DATA_WIDTH  one pixel, all channels, raster order.
REQ-011 out_valid  output  1  window pixel on neuron_out is valid.
REQ-012 count  output  KERNAL_SIZE**2  window pixel position, 1..KERNAL_SIZE**2; 0 when idle.
REQ-013 neuron_out  output  DEPTH*DATA_WIDTH  window pixel to pool node.
REQ-014 frame_done  output  1  one-cycle pulse with the last window pixel of a frame.

Function
REQ-015 Feeder SHALL collect one strip (KERNAL_SIZE rows, KERNAL_SIZE*MAP_WIDTH pixels) from the input stream into a strip buffer, indexed by row-in-strip and column counters.
REQ-016 When a strip is complete, feeder SHALL drain it: windows left to right; within a window, row-major; one pixel per cycle with out_valid=1 and no output backpressure.
REQ-017 count SHALL be 1 on the first pixel of each window, increment each drain cycle, reach KERNAL_SIZE**2 on the last pixel, then restart at 1 for the next window with no gap cycle.
REQ-018 All outputs SHALL be registered; first drain pixel appears the cycle after the strip's last pixel is accepted.
REQ-019 States: FILL (accepting), DRAIN (emitting), FILL_DRAIN (both; macro-enabled only); FILL->DRAIN on strip-complete; DRAIN->FILL after pixel MAP_WIDTH*KERNAL_SIZE of the strip is emitted.
REQ-020 Column counter SHALL wrap to 0 at MAP_WIDTH-1; row counter wraps at KERNAL_SIZE-1; strip counter wraps at MAP_HEIGHT/KERNAL_SIZE-1.
REQ-021 frame_done SHALL assert exactly on the count==KERNAL_SIZE**2 cycle of the last window of the last strip.
REQ-022 Outside drain, out_valid=0, count=0, neuron_out holds last value.
REQ-023 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-024 Reset SHALL return state to FILL, zero all counters, out_valid=0, count=0, frame_done=0, neuron_out=0, in_ready=1 after deassertion.
REQ-025 Reset mid-strip or mid-drain SHALL discard buffered pixels; buffer contents need not be cleared.

Configuration
REQ-026 Macro POOL_FEEDER_PINGPONG_EN defined: two strip buffers; next strip fills while current drains; in_ready=0 only when both buffers are full/draining.
REQ-027 Macro undefined: one strip buffer; in_ready=0 for the whole drain; resumes the cycle after the last drain pixel.

Structure
REQ-028 Shared package pool_pkg SHALL hold the state enum and count/width helper constants, shared with pool_node.
REQ-029 One sub-module, strip_buffer (one write port, one registered read port), instantiated once or twice per macro.

Verification (KERNAL_SIZE=2, MAP_WIDTH=4, MAP_HEIGHT=4, DEPTH=1, pixel value = raster index)
REQ-030 Continuous input 0..15 -> output sequence 0,1,4,5 / 2,3,6,7 / 8,9,12,13 / 10,11,14,15 with count 1,2,3,4 repeating; frame_done only with pixel 15.
REQ-031 Macro undefined, continuous in_valid -> in_ready low for exactly 8 cycles after pixel 7 accepted; no pixel lost.
REQ-032 Macro defined, continuous in_valid -> pixels 8..15 accepted while pixels 0..7 drain; in_ready never low in first frame.
REQ-033 in_valid toggled 1/0 every cycle -> identical output sequence to REQ-030, delayed only.
REQ-034 Reset asserted after pixel 5 accepted, then stream 0..15 -> output identical to REQ-030, no stale pixels, count=0 during reset.
